j_intresp: RTL and testbench
============================

Name: j_intresp

Overview:
- Interrupt responder on the DSP side of the misc block's interrupt controller.
- Consumes the controller's interrupt level and pending vector, picks the highest-priority source and presents a vector to the DSP core with a request/acknowledge handshake.
- On core acknowledge, arbitrates for the register bus and issues the acknowledge write (ack mask in bits 13:8, enables in bits 5:0) that clears the serviced latch.
- Blocks nesting until the core signals return-from-interrupt plus a programmable holdoff.

Parameters:
- NSRC, 6, number of interrupt sources; fixed at 6, matching the controller.
- HOLDOFF, 4, clk cycles after cpu_iret before a new request may be raised (0..255).
- HI_FIRST, 0, priority order: 0 means bit 0 is highest priority; 1 means bit NSRC-1 is highest.

Ports:
- clk  in  1  system clock; all state on rising edge.
- resetl  in  1  asynchronous active-low reset.
- irq  in  1  interrupt level from controller (OR of pending latches).
- pend  in  6  controller pending latches.
- ie_cur  in  6  current enable mask; re-written unchanged in the ack write.
- cpu_irq  out  1  interrupt request to DSP core.
- cpu_vec  out  3  index of requested source, valid while cpu_irq=1 and held through service.
- cpu_iack  in  1  one-cycle core acknowledge.
- cpu_iret  in  1  one-cycle end-of-service from core.
- wr_req  out  1  register-bus request for the ack write.
- wr_gnt  in  1  register-bus grant.
- int1w  out  1  one-cycle write strobe to the controller's interrupt register.
- dout  out  16  write data; valid only while int1w=1, 0 otherwise.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, all outputs 0, vector register 0, holdoff counter 0.
- Eligible set: E = pend & {6{irq}}.
- Priority encode: sel = lowest set index of E when HI_FIRST=0, highest set index when HI_FIRST=1.
- IDLE:
  - If E≠0 and holdoff counter = 0: latch cpu_vec=sel and go to REQ. cpu_irq rises the cycle after detection.
  - Otherwise stay in IDLE.
- REQ (cpu_irq=1, cpu_vec stable):
  - cpu_iack=1: go to ACKW. cpu_iack takes precedence over the withdraw check in the same cycle.
  - pend[cpu_vec]=0 without cpu_iack (source cleared elsewhere): withdraw. cpu_irq drops next cycle; go to IDLE with no holdoff.
  - A higher-priority source arriving in REQ does not change cpu_vec.
- ACKW (cpu_irq=0):
  - Hold wr_req=1 until wr_gnt=1 is sampled.
  - In the cycle after the grant: int1w=1 for exactly one cycle, dout = {2'b00, onehot6(cpu_vec), 2'b00, ie_cur}, wr_req=0. Go to SERV.
  - Latency from cpu_iack to int1w: 2 cycles when the grant is immediate.
- SERV:
  - No request is raised; cpu_vec is held.
  - On cpu_iret: load holdoff counter with HOLDOFF, go to IDLE.
  - cpu_iret seen in REQ or ACKW is ignored.
- Holdoff counter: 8-bit; decrements by 1 per cycle while nonzero and never goes below 0. HOLDOFF=0 allows a request to be detected in the cycle after cpu_iret.
- cpu_iack outside REQ is ignored.
- wr_gnt is ignored when wr_req=0.
- busy = (state≠IDLE).

Test Plan:
- Basic service: reset; pend=6'b000100, irq=1, ie_cur=6'h3F, immediate grant.
  - cpu_irq=1, cpu_vec=2.
  - cpu_iack, then two cycles later int1w pulses once with dout=16'h043F.
  - After cpu_iret and 4 idle cycles, a still-pending source re-requests.
- Priority: pend=6'b100010.
  - HI_FIRST=0 → cpu_vec=1, dout[13:8]=6'b000010.
  - HI_FIRST=1 → cpu_vec=5, dout[13:8]=6'b100000.
- Withdraw: in REQ with cpu_vec=3, drop pend[3] before cpu_iack.
  - cpu_irq falls next cycle; no int1w ever.
  - Next source is requested immediately, with no holdoff.
- Bus stall: hold wr_gnt=0 for 10 cycles after cpu_iack.
  - wr_req stays 1 and int1w stays 0 for all 10 cycles.
  - Exactly one int1w one cycle after the grant.
- Reset mid-operation: assert resetl=0 asynchronously in ACKW with wr_req=1.
  - All outputs go to 0 immediately.
  - After release, a pending source restarts from IDLE with a new request.
- Nesting and iret timing:
  - A new pend bit during SERV raises no cpu_irq.
  - A stray cpu_iret in REQ is ignored.
  - cpu_iret in SERV with HOLDOFF=4 puts cpu_irq back within 6 cycles.

Source files
------------

// File: rtl/j_intresp.sv
// Interrupt responder: prioritises the controller's pending sources and presents a vector to the DSP core.
// On acknowledge it issues the ack write over the register bus, then blocks nesting until iret plus a holdoff.
module j_intresp #(
   parameter int unsigned NSRC     = 6,
   parameter int unsigned HOLDOFF  = 4,
   parameter int unsigned HI_FIRST = 0
) (
   input  logic            clk,
   input  logic            resetl,
   input  logic            irq,
   input  logic [NSRC-1:0] pend,
   input  logic [NSRC-1:0] ie_cur,
   output logic            cpu_irq,
   output logic [2:0]      cpu_vec,
   input  logic            cpu_iack,
   input  logic            cpu_iret,
   output logic            wr_req,
   input  logic            wr_gnt,
   output logic            int1w,
   output logic [15:0]     dout,
   output logic            busy
);

   localparam int unsigned VEC_W  = 3;
   localparam int unsigned HOLD_W = 8;

   typedef enum logic [1:0] {IDLE, REQ, ACKW, SERV} state_t;

   state_t            state, state_n;
   logic [HOLD_W-1:0] hold;
   logic [NSRC-1:0]   elig;
   logic [NSRC-1:0]   onehot;
   logic [VEC_W-1:0]  sel;

   logic              irq_n;
   logic [VEC_W-1:0]  vec_n;
   logic              wr_req_n;
   logic              int1w_n;
   logic [15:0]       dout_n;
   logic              busy_n;

   assign elig   = pend & {NSRC{irq}};
   assign onehot = NSRC'(1) << cpu_vec;

   // Priority encoder; the last match in scan order wins, so scan from lowest to highest priority.
   always_comb begin : prio_enc
      sel = '0;
      for (int i = 0; i < int'(NSRC); i++) begin
         if (HI_FIRST != 0) begin
            if (elig[i]) sel = VEC_W'(i);
         end else begin
            if (elig[int'(NSRC) - 1 - i]) sel = VEC_W'(int'(NSRC) - 1 - i);
         end
      end
   end

   always_ff @(posedge clk or negedge resetl) begin : state_reg
      if (!resetl) state <= IDLE;
      else         state <= state_n;
   end

   // Acknowledge wins over withdraw when both arrive in the same REQ cycle.
   always_comb begin : next_state
      state_n = state;
      unique case (state)
         IDLE:    if (elig != '0 && hold == '0) state_n = REQ;
         REQ: begin
            if (cpu_iack)           state_n = ACKW;
            else if (!pend[cpu_vec]) state_n = IDLE;
         end
         ACKW:    if (wr_gnt)   state_n = SERV;
         SERV:    if (cpu_iret) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin : output_next
      irq_n    = 1'b0;
      vec_n    = cpu_vec;
      wr_req_n = 1'b0;
      int1w_n  = 1'b0;
      dout_n   = '0;
      busy_n   = (state_n != IDLE);
      unique case (state)
         IDLE: begin
            if (state_n == REQ) begin
               irq_n = 1'b1;
               vec_n = sel;
            end
         end
         REQ: begin
            irq_n    = (state_n == REQ);
            wr_req_n = (state_n == ACKW);
         end
         ACKW: begin
            if (state_n == SERV) begin
               int1w_n = 1'b1;
               dout_n  = {2'b00, onehot, 2'b00, ie_cur};
            end else begin
               wr_req_n = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge resetl) begin : output_reg
      if (!resetl) begin
         cpu_irq <= 1'b0;
         cpu_vec <= '0;
         wr_req  <= 1'b0;
         int1w   <= 1'b0;
         dout    <= '0;
         busy    <= 1'b0;
      end else begin
         cpu_irq <= irq_n;
         cpu_vec <= vec_n;
         wr_req  <= wr_req_n;
         int1w   <= int1w_n;
         dout    <= dout_n;
         busy    <= busy_n;
      end
   end

   // Holdoff is armed on iret out of service and drains to zero, saturating there.
   always_ff @(posedge clk or negedge resetl) begin : holdoff_reg
      if (!resetl) begin
         hold <= '0;
      end else if (state == SERV && cpu_iret) begin
         hold <= HOLD_W'(HOLDOFF);
      end else if (hold != '0) begin
         hold <= hold - HOLD_W'(1);
      end
   end

endmodule

// File: tb/tb_j_intresp.sv
// Bench for j_intresp: directed scenarios plus randomized service transactions against a
// transaction-level model (priority via bit arithmetic, expected ack word, holdoff latency).
module tb_j_intresp;

   logic        clk = 1'b0;
   logic        resetl, irq, cpu_iack, cpu_iret, wr_gnt;
   logic [5:0]  pend, ie_cur;
   logic        cpu_irq0, cpu_irq1, wr_req0, wr_req1, int1w0, int1w1, busy0, busy1;
   logic [2:0]  vec0, vec1;
   logic [15:0] dout0, dout1;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   j_intresp #(.NSRC(6), .HOLDOFF(4), .HI_FIRST(0)) dut0 (
      .clk(clk), .resetl(resetl), .irq(irq), .pend(pend), .ie_cur(ie_cur),
      .cpu_irq(cpu_irq0), .cpu_vec(vec0), .cpu_iack(cpu_iack), .cpu_iret(cpu_iret),
      .wr_req(wr_req0), .wr_gnt(wr_gnt), .int1w(int1w0), .dout(dout0), .busy(busy0));

   j_intresp #(.NSRC(6), .HOLDOFF(4), .HI_FIRST(1)) dut1 (
      .clk(clk), .resetl(resetl), .irq(irq), .pend(pend), .ie_cur(ie_cur),
      .cpu_irq(cpu_irq1), .cpu_vec(vec1), .cpu_iack(cpu_iack), .cpu_iret(cpu_iret),
      .wr_req(wr_req1), .wr_gnt(wr_gnt), .int1w(int1w1), .dout(dout1), .busy(busy1));

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Lowest set bit via x & -x, highest via clog2(x+1)-1.
   function automatic logic [2:0] exp_vec(input logic [5:0] p, input bit hi);
      int x;
      x = int'(p);
      if (hi) return 3'($clog2(x + 1) - 1);
      return 3'($clog2(x & -x));
   endfunction

   function automatic logic [15:0] exp_dout(input logic [2:0] v, input logic [5:0] ie);
      int w;
      w = ((1 << v) << 8) | int'(ie);
      return 16'(w);
   endfunction

   task automatic wait_irq(input int max, output int n);
      n = 0;
      while (cpu_irq0 !== 1'b1 && n < max) begin
         tick();
         n++;
      end
   endtask

   // One full transaction from IDLE (holdoff expired) back to IDLE.
   task automatic serve(input logic [5:0] p, input logic [5:0] ie, input int gdelay,
                        input logic [5:0] extra, input bit gate);
      int n, k;
      logic [5:0] p2;
      pend = p; ie_cur = ie;
      if (gate) begin
         irq = 1'b0;
         tick(); tick();
         chk("gated_no_req", 16'(cpu_irq0), 16'd0);
      end
      irq = 1'b1;
      wait_irq(8, n);
      chk("req_lat", 16'(n), 16'd1);
      chk("req_vec0", 16'(vec0), 16'(exp_vec(p, 1'b0)));
      chk("req_vec1", 16'(vec1), 16'(exp_vec(p, 1'b1)));
      cpu_iret = 1'b1; tick(); cpu_iret = 1'b0;
      chk("iret_in_req", 16'(cpu_irq0), 16'd1);
      chk("vec_stable", 16'(vec0), 16'(exp_vec(p, 1'b0)));
      cpu_iack = 1'b1; tick(); cpu_iack = 1'b0;
      chk("ackw_irq", 16'(cpu_irq0), 16'd0);
      chk("ackw_wrreq", 16'(wr_req0), 16'd1);
      wr_gnt = 1'b0;
      for (int i = 0; i < gdelay; i++) begin
         tick();
         chk("stall_wrreq", 16'(wr_req0), 16'd1);
         chk("stall_int1w", 16'(int1w0), 16'd0);
      end
      wr_gnt = 1'b1; tick(); wr_gnt = 1'b0;
      chk("int1w", 16'(int1w0), 16'd1);
      chk("wrreq_drop", 16'(wr_req0), 16'd0);
      chk("dout0", dout0, exp_dout(exp_vec(p, 1'b0), ie));
      chk("dout1", dout1, exp_dout(exp_vec(p, 1'b1), ie));
      tick();
      chk("int1w_once", 16'(int1w0), 16'd0);
      chk("dout_idle", dout0, 16'd0);
      p2 = p | extra;
      pend = p2;
      tick(); tick();
      chk("serv_no_irq", 16'(cpu_irq0), 16'd0);
      chk("serv_busy", 16'(busy0), 16'd1);
      chk("serv_vec", 16'(vec0), 16'(exp_vec(p, 1'b0)));
      cpu_iret = 1'b1; tick(); cpu_iret = 1'b0;
      chk("iret_idle", 16'(busy0), 16'd0);
      k = 0;
      do begin
         tick();
         k++;
      end while (cpu_irq0 !== 1'b1 && k < 12);
      chk("holdoff_lat", 16'(k), 16'd5);
      chk("rereq_vec0", 16'(vec0), 16'(exp_vec(p2, 1'b0)));
      chk("rereq_vec1", 16'(vec1), 16'(exp_vec(p2, 1'b1)));
      pend = '0; tick();
      chk("withdraw_irq", 16'(cpu_irq0), 16'd0);
      chk("withdraw_busy", 16'(busy0), 16'd0);
   endtask

   initial begin
      int n;
      resetl = 1'b0; irq = 1'b0; pend = '0; ie_cur = '0;
      cpu_iack = 1'b0; cpu_iret = 1'b0; wr_gnt = 1'b0;
      tick(); tick();
      chk("rst_irq", 16'(cpu_irq0), 16'd0);
      chk("rst_vec", 16'(vec0), 16'd0);
      chk("rst_wrreq", 16'(wr_req0), 16'd0);
      chk("rst_int1w", 16'(int1w0), 16'd0);
      chk("rst_dout", dout0, 16'd0);
      chk("rst_busy", 16'(busy0), 16'd0);
      resetl = 1'b1;
      tick();

      // Acknowledge and grant outside their states do nothing.
      irq = 1'b1;
      cpu_iack = 1'b1; tick(); cpu_iack = 1'b0;
      chk("iack_idle", 16'(busy0), 16'd0);
      wr_gnt = 1'b1; tick(); wr_gnt = 1'b0;
      tick();
      chk("gnt_idle_int1w", 16'(int1w0), 16'd0);
      chk("gnt_idle_wrreq", 16'(wr_req0), 16'd0);

      serve(6'b000100, 6'h3F, 0, 6'b000000, 1'b0);
      serve(6'b100010, 6'h3F, 0, 6'b000000, 1'b0);

      // Withdraw: source 3 clears before acknowledge, source 5 follows at once.
      pend = 6'b101000; irq = 1'b1;
      wait_irq(8, n);
      chk("wd_lat", 16'(n), 16'd1);
      chk("wd_vec", 16'(vec0), 16'd3);
      pend = 6'b100000; tick();
      chk("wd_drop", 16'(cpu_irq0), 16'd0);
      chk("wd_int1w", 16'(int1w0), 16'd0);
      tick();
      chk("wd_next", 16'(cpu_irq0), 16'd1);
      chk("wd_next_vec", 16'(vec0), 16'd5);
      pend = '0; tick();
      chk("wd_clear", 16'(cpu_irq0), 16'd0);
      chk("wd_no_int1w", 16'(int1w0), 16'd0);

      serve(6'b001000, 6'h2A, 10, 6'b000001, 1'b0);

      // Asynchronous reset while waiting for the bus.
      pend = 6'b010000; ie_cur = 6'h15; irq = 1'b1;
      wait_irq(8, n);
      chk("mr_pre_irq", 16'(cpu_irq0), 16'd1);
      cpu_iack = 1'b1; tick(); cpu_iack = 1'b0;
      tick();
      chk("mr_pre_wrreq", 16'(wr_req0), 16'd1);
      #2 resetl = 1'b0;
      #1;
      chk("mr_irq", 16'(cpu_irq0), 16'd0);
      chk("mr_wrreq", 16'(wr_req0), 16'd0);
      chk("mr_int1w", 16'(int1w0), 16'd0);
      chk("mr_busy", 16'(busy0), 16'd0);
      chk("mr_vec", 16'(vec0), 16'd0);
      chk("mr_dout", dout0, 16'd0);
      tick();
      resetl = 1'b1;
      wait_irq(8, n);
      chk("mr_restart_lat", 16'(n), 16'd1);
      chk("mr_restart_vec", 16'(vec0), 16'd4);
      pend = '0; tick();
      chk("mr_clear", 16'(cpu_irq0), 16'd0);

      for (int it = 0; it < 20; it++) begin
         logic [5:0] rp, rie, rx;
         int         rg;
         bit         rgate;
         rp    = 6'($urandom_range(1, 63));
         rie   = 6'($urandom);
         rx    = 6'($urandom);
         rg    = int'($urandom_range(0, 4));
         rgate = 1'($urandom);
         serve(rp, rie, rg, rx, rgate);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
